// File: rtl/vector_buffer_pkg.sv
// Shared definitions for the vector buffer: control-state encoding and
// width derivation helpers for element positions and counts.
package vector_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Width of a position 0..count-1.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Width of a count 0..count (one more value than a position).
  function automatic int length_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/vector_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Contents are never reset.
module vector_mem
  import vector_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int DEPTH      = 127,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Addresses past the last slot can appear on the read port during the
  // final shift step; they are simply not fetched.
  always_ff @(posedge clk) begin
    if (i_we && (int'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (int'(i_rd_addr) < DEPTH) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vector_buffer.sv
// Ordered element sequence with indexed get, insert and remove. Insert and
// remove move the tail one element per cycle while ready is low.
module vector_buffer
  import vector_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH   = 7,
  parameter  int DATA_COUNT   = 127,
  localparam int INDEX_WIDTH  = index_width(DATA_COUNT),
  localparam int LENGTH_WIDTH = length_width(DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic                    get,
  input  logic                    insert,
  input  logic                    remove,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [LENGTH_WIDTH-1:0] length,
  output logic                    ready
);

  localparam logic [LENGTH_WIDTH-1:0] L_ONE = LENGTH_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0] L_TWO = LENGTH_WIDTH'(2);
  localparam logic [LENGTH_WIDTH-1:0] L_MAX = LENGTH_WIDTH'(DATA_COUNT);

  state_t                  r_state, w_state_next;
  logic [LENGTH_WIDTH-1:0] r_length, w_length_next;
  logic [LENGTH_WIDTH-1:0] r_pos, w_pos_next;
  logic [LENGTH_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_op_ins;
  logic                    r_sel_ram;
  logic [DATA_WIDTH-1:0]   r_hold;

  logic [LENGTH_WIDTH-1:0] w_idx_ext;
  logic                    w_idle;
  logic                    w_ins_ok, w_rem_ok;
  logic                    w_ins_acc, w_rem_acc, w_get_acc, w_get_in_range;
  logic                    w_we;
  logic [INDEX_WIDTH-1:0]  w_wr_addr, w_rd_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data, w_rd_data;

  assign w_idx_ext      = LENGTH_WIDTH'(index);
  assign w_idle         = (r_state == ST_IDLE);
  assign w_ins_ok       = insert && (r_length < L_MAX) && (w_idx_ext <= r_length);
  assign w_rem_ok       = remove && (w_idx_ext < r_length);
  assign w_rem_acc      = w_idle && w_rem_ok;
  assign w_ins_acc      = w_idle && w_ins_ok && !w_rem_ok;
  assign w_get_acc      = w_idle && get && !w_ins_acc && !w_rem_acc;
  assign w_get_in_range = (w_idx_ext < r_length);

  // The read port runs one step ahead of the write port, so each shift
  // step writes the element fetched in the previous cycle.
  always_comb begin
    w_state_next  = r_state;
    w_pos_next    = r_pos;
    w_length_next = r_length;
    w_we          = 1'b0;
    w_wr_addr     = INDEX_WIDTH'(r_pos);
    w_wr_data     = w_rd_data;
    w_rd_addr     = index;
    case (r_state)
      ST_IDLE: begin
        if (w_rem_acc) begin
          w_state_next = ST_SHIFT;
          w_pos_next   = w_idx_ext;
          w_rd_addr    = INDEX_WIDTH'(w_idx_ext + L_ONE);
        end else if (w_ins_acc) begin
          w_state_next = ST_SHIFT;
          w_pos_next   = r_length;
          w_rd_addr    = INDEX_WIDTH'(r_length - L_ONE);
        end
      end
      ST_SHIFT: begin
        if (r_op_ins) begin
          w_we = 1'b1;
          if (r_pos == r_idx) begin
            w_wr_data     = r_data;
            w_length_next = r_length + L_ONE;
            w_state_next  = ST_IDLE;
          end else begin
            w_pos_next = r_pos - L_ONE;
            w_rd_addr  = INDEX_WIDTH'(r_pos - L_TWO);
          end
        end else begin
          if ((r_pos + L_ONE) == r_length) begin
            w_length_next = r_length - L_ONE;
            w_state_next  = ST_IDLE;
          end else begin
            w_we       = 1'b1;
            w_pos_next = r_pos + L_ONE;
            w_rd_addr  = INDEX_WIDTH'(r_pos + L_TWO);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_length  <= '0;
      r_pos     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_op_ins  <= 1'b0;
      r_sel_ram <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_length <= w_length_next;
      r_pos    <= w_pos_next;
      if (w_ins_acc || w_rem_acc) begin
        r_op_ins <= w_ins_acc;
        r_idx    <= w_idx_ext;
        r_data   <= data_in;
      end
      r_sel_ram <= w_get_acc && w_get_in_range;
      r_hold    <= (w_get_acc && !w_get_in_range) ? '0 : data_out;
    end
  end

  // A get result comes straight from the RAM output register for one cycle,
  // then is held locally so later shifts cannot disturb it.
  assign data_out = r_sel_ram ? w_rd_data : r_hold;
  assign length   = r_length;
  assign ready    = w_idle;

  vector_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DATA_COUNT),
    .ADDR_WIDTH (INDEX_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_vector_buffer.sv
// Directed bench for vector_buffer: handshake timing, get readback,
// capacity limits, priority and reset abort.
module tb_vector_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] index = '0;
  logic       get = 1'b0;
  logic       insert = 1'b0;
  logic       remove = 1'b0;
  logic [6:0] data_in = '0;
  logic [6:0] data_out;
  logic [7:0] length;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;
  int low;

  always #5 clk = ~clk;

  vector_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .index    (index),
    .get      (get),
    .insert   (insert),
    .remove   (remove),
    .data_in  (data_in),
    .data_out (data_out),
    .length   (length),
    .ready    (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Issue one insert/remove request and count cycles with ready low.
  task automatic op(input logic ins, input logic rem, input int idx, input int d, output int n_low);
    @(negedge clk);
    index   = 7'(idx);
    data_in = 7'(d);
    insert  = ins;
    remove  = rem;
    @(negedge clk);
    insert = 1'b0;
    remove = 1'b0;
    n_low  = 0;
    while (ready !== 1'b1 && n_low < 300) begin
      n_low++;
      @(negedge clk);
    end
  endtask

  // Back-to-back gets of 0..len(s); expects the string then a trailing 0.
  task automatic readback(input string tag, input string s);
    @(negedge clk);
    get   = 1'b1;
    index = 7'd0;
    for (int k = 1; k <= s.len() + 1; k++) begin
      @(negedge clk);
      if (k - 1 < s.len()) check($sformatf("%s[%0d]", tag, k - 1), 32'(data_out), 32'(s[k-1]));
      else                 check($sformatf("%s[end]", tag), 32'(data_out), 32'd0);
      if (k <= s.len()) index = 7'(k);
      else              get = 1'b0;
    end
  endtask

  task automatic get_one(input string tag, input int idx, input int exp);
    @(negedge clk);
    index = 7'(idx);
    get   = 1'b1;
    @(negedge clk);
    get = 1'b0;
    check(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_length", 32'(length), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    get_one("get_empty", 0, 0);

    op(1'b1, 1'b0, 0, 97, low);  check("app_a_low", 32'(low), 32'd1);
    op(1'b1, 1'b0, 1, 98, low);  check("app_b_low", 32'(low), 32'd1);
    op(1'b1, 1'b0, 2, 99, low);  check("app_c_low", 32'(low), 32'd1);
    check("len_abc", 32'(length), 32'd3);
    readback("rd_abc", "abc");

    op(1'b1, 1'b0, 0, 120, low); check("ins_x_low", 32'(low), 32'd4);
    check("len_xabc", 32'(length), 32'd4);
    readback("rd_xabc", "xabc");

    op(1'b0, 1'b1, 1, 0, low);   check("rem1_low", 32'(low), 32'd3);
    check("len_xbc", 32'(length), 32'd3);
    readback("rd_xbc", "xbc");

    op(1'b0, 1'b1, 3, 0, low);   check("rem_oob_low", 32'(low), 32'd0);
    check("rem_oob_len", 32'(length), 32'd3);
    op(1'b1, 1'b0, 5, 7, low);   check("ins_gap_low", 32'(low), 32'd0);
    check("ins_gap_len", 32'(length), 32'd3);

    for (int k = 3; k < 127; k++) op(1'b1, 1'b0, k, k, low);
    check("fill_len", 32'(length), 32'd127);
    get_one("fill_get126", 126, 126);
    op(1'b1, 1'b0, 10, 55, low); check("ins_full_low", 32'(low), 32'd0);
    check("ins_full_len", 32'(length), 32'd127);

    op(1'b1, 1'b1, 5, 99, low);  check("both_low", 32'(low), 32'd122);
    check("both_len", 32'(length), 32'd126);
    get_one("both_get5", 5, 6);
    get_one("both_get4", 4, 4);
    get_one("both_get125", 125, 126);
    get_one("both_get126", 126, 0);
    get_one("both_get0", 0, 120);

    @(negedge clk);
    index   = 7'd0;
    data_in = 7'd113;
    insert  = 1'b1;
    @(negedge clk);
    insert = 1'b0;
    check("shift_busy", 32'(ready), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_len", 32'(length), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    op(1'b1, 1'b0, 0, 122, low); check("post_app_low", 32'(low), 32'd1);
    check("post_app_len", 32'(length), 32'd1);
    readback("rd_z", "z");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_buffer.md
# vector_buffer

Fixed-capacity ordered sequence of `DATA_WIDTH`-bit elements supporting indexed read, insert-at-index and remove-at-index. It is the storage behind the text editor buffer: the editor inserts and deletes symbols at the cursor and streams the contents out for display. Insert and remove shift the tail one element per cycle behind a `ready` handshake. Get is single-cycle pipelined.

## Interface
- `DATA_WIDTH`, 7: element width in bits.
- `DATA_COUNT`, 127: maximum number of elements.
- Derived: `INDEX_WIDTH = $clog2(DATA_COUNT)`; `LENGTH_WIDTH = $clog2(DATA_COUNT+1)`.

- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `index`  in  INDEX_WIDTH  target position for get/insert/remove. Hold stable while `ready` is low.
- `get`  in  1  read request for `mem[index]`.
- `insert`  in  1  insert `data_in` at `index`.
- `remove`  in  1  delete the element at `index`.
- `data_in`  in  DATA_WIDTH  element to insert. Hold stable while `ready` is low.
- `data_out`  out  DATA_WIDTH  registered get result.
- `length`  out  LENGTH_WIDTH  current element count.
- `ready`  out  1  high when idle and able to accept insert/remove.

## Operation
- States: IDLE (`ready`=1) and SHIFT (`ready`=0).
- Reset values: `length`=0, `ready`=1, `data_out`=0, state IDLE. Storage contents are not reset.
- Reset asserted mid-SHIFT aborts the operation, returns to IDLE, and sets `length` to 0.
- Insert is accepted in IDLE when `length < DATA_COUNT` and `index <= length`. `index == length` appends. Otherwise it is ignored and `ready` stays 1.
- Insert effect: elements `[index..L-1]` move to `[index+1..L]`, processed from the top down. Then `mem[index] = data_in` and `length` becomes L+1.
- Remove is accepted in IDLE when `index < length`. Otherwise it is ignored.
- Remove effect: elements `[index+1..L-1]` move to `[index..L-2]`, processed from the bottom up. Then `length` becomes L-1.
- Simultaneous insert and remove: remove wins and insert is dropped.
- Get has priority below neither: it acts only in IDLE and only when neither insert nor remove is accepted that cycle. Get in SHIFT is ignored and `data_out` holds.
- Get result: `data_out <= (index < length) ? mem[index] : 0`. Reading at `index == length` is legal and returns 0 (the editor reads one past the end for the trailing cursor).
- `data_out` holds its value when there is no get.
- Index and arithmetic width: internal position counters use LENGTH_WIDTH. No wrap-around is permitted.

## Timing
- Get: request in cycle t, `data_out` valid in cycle t+1. Back-to-back gets are allowed every cycle, giving throughput 1/cycle.
- Insert accepted in cycle t at position i with length L:
  - `ready` is 0 for exactly (L−i)+1 cycles, from t+1 through t+(L−i)+1.
  - `ready` returns to 1 in cycle t+(L−i)+2.
  - `length` shows L+1 in that same cycle.
- Remove accepted in cycle t at position i:
  - `ready` is 0 for exactly L−i cycles, with a minimum of 1.
  - `length` shows L−1 when `ready` returns to 1.
- `ready` is registered. It drops in the cycle after acceptance, never combinationally in the request cycle.
- The requester keeps `index` and `data_in` stable until it sees `ready`=1. Insert/remove held high during SHIFT are ignored. They are not queued.

## Structure
- Storage: one `DATA_COUNT x DATA_WIDTH` array, inferred as RAM. Use a register array if it has 1-cycle read.
- Control: one FSM with position counter, length register, and saved op/data.
- Shared package: the state encoding and the `INDEX_WIDTH`/`LENGTH_WIDTH` derivation helpers.
- One sub-module is natural: `vector_mem`, a simple dual-port RAM (one write port, one synchronous read port).

## Test plan
- Reset → `length`=0, `ready`=1, `data_out`=0. Get at index 0 → `data_out`=0 next cycle.
- Append 'a','b','c' at indices 0,1,2, waiting for `ready` between each. Each `ready` low exactly 1 cycle. Then get 0..3 on consecutive cycles → 'a','b','c',0, one cycle after each request.
- With contents "abc", insert 'x' at 0 → `ready` low 4 cycles, `length`=4. Readback gives "xabc".
- With contents "xabc", remove at 1 → `ready` low 3 cycles. Readback gives "xbc". Remove at index 3 when `length`=3 → ignored, `ready` stays 1.
- Fill to `DATA_COUNT`=127, then insert → ignored, `length` stays 127. Insert and remove together at index 5 → only the remove is performed.
- Assert `reset` during a SHIFT → immediate `ready`=1 and `length`=0. A subsequent append at 0 works.
